// File: rtl/vga_plot_arbiter_if.sv
// Pixel-source and VGA-adapter signal bundle for vga_plot_arbiter.
// Sources drive the master side; the arbiter takes the slave side.
interface vga_plot_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3
);
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     pix_valid;
  logic [N_REQ-1:0]     pix_last;
  logic [N_REQ*X_W-1:0] pix_x;
  logic [N_REQ*Y_W-1:0] pix_y;
  logic [N_REQ*C_W-1:0] pix_colour;
  logic [N_REQ-1:0]     gnt;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic                 abort;
  logic [X_W-1:0]       vga_x;
  logic [Y_W-1:0]       vga_y;
  logic [C_W-1:0]       vga_colour;
  logic                 vga_plot;

  modport master (
    output req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
    input  gnt, gnt_id, busy, abort, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
    output gnt, gnt_id, busy, abort, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing the VGA pixel-write port between pixel sources.
// Optional macro PLOT_CLIP_EN suppresses vga_plot for off-screen pixels.
//
// state   | meaning
// S_IDLE  | no grant held; pick next requester from rr_ptr upward
// S_GRANT | forwarding pixels of source gnt_id until last pixel or req drop
module vga_plot_arbiter #(
  parameter int N_REQ    = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic             clk,
  input logic             reset,
  vga_plot_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > 4 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_param
    $error("vga_plot_arbiter: unsupported parameter set");
  end

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t           r_state, w_next_state;
  logic [1:0]       r_rr_ptr, r_gnt_id, w_pick_id, w_next_rr, w_idx;
  logic [2:0]       w_sum;
  logic [N_REQ-1:0] r_gnt, w_pick_hot;
  logic             r_busy, r_abort, r_plot;
  logic             w_found, w_last, w_drop, w_onscreen;
  logic [X_W-1:0]   r_vga_x, w_x;
  logic [Y_W-1:0]   r_vga_y, w_y;
  logic [C_W-1:0]   r_vga_colour, w_colour;

  // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_pick_id  = r_rr_ptr;
    w_pick_hot = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      if (w_sum >= 3'(N_REQ)) w_sum = w_sum - 3'(N_REQ);
      w_idx = w_sum[1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found           = 1'b1;
        w_pick_id         = w_idx;
        w_pick_hot        = '0;
        w_pick_hot[w_idx] = 1'b1;
      end
    end
  end

  assign w_x       = bus.pix_x[int'(r_gnt_id)*X_W +: X_W];
  assign w_y       = bus.pix_y[int'(r_gnt_id)*Y_W +: Y_W];
  assign w_colour  = bus.pix_colour[int'(r_gnt_id)*C_W +: C_W];
  assign w_next_rr = (int'(r_gnt_id) == N_REQ - 1) ? 2'd0 : r_gnt_id + 2'd1;

`ifdef PLOT_CLIP_EN
  localparam logic [X_W:0] LP_SCREEN_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LP_SCREEN_H = (Y_W+1)'(SCREEN_H);
  assign w_onscreen = ({1'b0, w_x} < LP_SCREEN_W) && ({1'b0, w_y} < LP_SCREEN_H);
`else
  assign w_onscreen = 1'b1;
`endif

  always_comb begin
    w_last       = bus.pix_valid[r_gnt_id] && bus.pix_last[r_gnt_id];
    w_drop       = !bus.req[r_gnt_id] && !w_last;
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_GRANT;
      S_GRANT: if (w_last || w_drop) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt        <= '0;
      r_gnt_id     <= '0;
      r_busy       <= 1'b0;
      r_abort      <= 1'b0;
      r_rr_ptr     <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_plot       <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (r_state == S_IDLE) begin
        r_plot <= 1'b0;
        if (w_found) begin
          r_gnt    <= w_pick_hot;
          r_gnt_id <= w_pick_id;
          r_busy   <= 1'b1;
        end
      end else begin
        // Coordinates follow the granted source even on gaps; only plot is gated.
        r_vga_x      <= w_x;
        r_vga_y      <= w_y;
        r_vga_colour <= w_colour;
        r_plot       <= bus.pix_valid[r_gnt_id] && w_onscreen;
        if (w_last || w_drop) begin
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_rr;
          r_abort  <= w_drop;
        end
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.gnt_id     = r_gnt_id;
  assign bus.busy       = r_busy;
  assign bus.abort      = r_abort;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_plot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: randomized sources, grant model, pixel queue.
// Honors PLOT_CLIP_EN when deciding which pixels should be plotted.
module tb_vga_plot_arbiter;
  localparam int N = 3, XW = 8, YW = 7, CW = 3, SW = 160, SH = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) bus();

  vga_plot_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW),
                     .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(rst), .bus(bus));

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    int            stamp;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0, n_err = 0, mcyc = 0;
  int   n_plots = 0, n_aborts = 0, seen50 = 0;
  int   glog[$], gaplog[$];
  bit   log_en = 1'b0;
  int   fall_cyc = 0;
  logic [N-1:0] prev_obs = '0;

  // Reference grant model: who should hold the port, and the round-robin pointer.
  logic [N-1:0] m_gnt = '0;
  int           m_id = 0, m_ptr = 0;
  logic         m_abort = 1'b0;

  // Source behaviour state.
  int s_phase[N], s_left[N], s_dropk[N], s_sent[N], s_wait[N];
  bit auto_en = 1'b0, g50 = 1'b0;
  int valid_pct = 100;
  int fx[$], fy[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (r[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic bit on_screen(input int x, input int y);
`ifdef PLOT_CLIP_EN
    return (x < SW) && (y < SH);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [XW-1:0] rand_x();
    logic [XW-1:0] t;
    t = XW'($urandom_range(0, 255));
    if (t == XW'(50)) t = XW'(51);
    return t;
  endfunction

  // Monitor: one pass per clock, after the edge settles.
  always begin
    int g;
    pix_t p;
    @(posedge clk);
    #1;
    mcyc++;
    if (rst) begin
      m_gnt = '0; m_id = 0; m_ptr = 0; m_abort = 1'b0;
      exp_q.delete();
      prev_obs = '0;
    end else begin
      if (m_gnt == '0) begin
        m_abort = 1'b0;
        g = rr_pick(bus.req, m_ptr);
        if (g >= 0) begin
          m_gnt = '0;
          m_gnt[2'(g)] = 1'b1;
          m_id = g;
        end
      end else if (bus.pix_valid[2'(m_id)] && bus.pix_last[2'(m_id)]) begin
        m_gnt = '0; m_ptr = (m_id + 1) % N; m_abort = 1'b0;
      end else if (!bus.req[2'(m_id)]) begin
        m_gnt = '0; m_ptr = (m_id + 1) % N; m_abort = 1'b1;
      end else begin
        m_abort = 1'b0;
      end
      check("gnt", 32'(bus.gnt), 32'(m_gnt));
      check("gnt_id", 32'(bus.gnt_id), 32'(m_id));
      check("busy", 32'(bus.busy), 32'(m_gnt != '0));
      check("abort", 32'(bus.abort), 32'(m_abort));
      if (bus.abort) n_aborts++;
      if (bus.vga_x == XW'(50)) seen50++;
      if (log_en && prev_obs != '0 && bus.gnt == '0) fall_cyc = mcyc;
      if (log_en && prev_obs == '0 && bus.gnt != '0) begin
        glog.push_back(int'(bus.gnt_id));
        gaplog.push_back(mcyc - fall_cyc);
      end
      prev_obs = bus.gnt;
      if (bus.vga_plot) begin
        n_plots++;
        check("plot_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          check("plot_pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, {p.x, p.y, p.c});
          check("plot_latency", 32'(mcyc - p.stamp), 32'd1);
        end
      end else if (exp_q.size() != 0) begin
        check("plot_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
  end

  task automatic start_burst(input int i, input int len, input int dropk);
    s_phase[i] = 1; s_left[i] = len; s_dropk[i] = dropk; s_sent[i] = 0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      s_phase[i] = 0; s_left[i] = 0; s_wait[i] = 0;
    end
    bus.req = '0; bus.pix_valid = '0; bus.pix_last = '0;
  endtask

  task automatic step();
    logic [N-1:0]    nreq, nval, nlast;
    logic [N*XW-1:0] px;
    logic [N*YW-1:0] py;
    logic [N*CW-1:0] pc;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   c;
    bit r, v, l;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      x = rand_x();
      y = YW'($urandom_range(0, 127));
      c = CW'($urandom_range(0, 7));
      r = 1'b0; v = 1'b0; l = 1'($urandom_range(0, 1));
      if (s_phase[i] == 0 && auto_en) begin
        if (s_wait[i] > 0) s_wait[i] = s_wait[i] - 1;
        else start_burst(i, $urandom_range(1, 6),
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1);
      end
      if (s_phase[i] == 1) begin
        r = 1'b1;
        if (m_gnt[i]) begin
          if (s_sent[i] == s_dropk[i]) begin
            r = 1'b0; l = 1'b0;
            s_phase[i] = 0; s_wait[i] = $urandom_range(0, 8);
          end else if ($urandom_range(1, 100) <= valid_pct) begin
            if (fx.size() != 0) begin
              x = XW'(fx.pop_front());
              y = YW'(fy.pop_front());
            end
            v = 1'b1;
            l = (s_left[i] == 1);
            s_left[i] = s_left[i] - 1;
            s_sent[i] = s_sent[i] + 1;
            if (on_screen(int'(x), int'(y)))
              exp_q.push_back('{x: x, y: y, c: c, stamp: mcyc});
          end
        end else if (s_left[i] == 0) begin
          r = 1'b0;
          s_phase[i] = 0; s_wait[i] = $urandom_range(0, 8);
        end
      end
      if (!m_gnt[i]) begin
        v = 1'($urandom_range(0, 1));
        if (g50 || $urandom_range(0, 1) == 1) x = XW'(50);
      end
      nreq[i] = r; nval[i] = v; nlast[i] = l;
      px[i*XW +: XW] = x; py[i*YW +: YW] = y; pc[i*CW +: CW] = c;
    end
    bus.req = nreq; bus.pix_valid = nval; bus.pix_last = nlast;
    bus.pix_x = px; bus.pix_y = py; bus.pix_colour = pc;
  endtask

  function automatic bit any_active();
    for (int i = 0; i < N; i++) if (s_phase[i] != 0) return 1'b1;
    return (m_gnt != '0);
  endfunction

  task automatic wait_idle(input int maxc, input string name);
    int c;
    c = 0;
    while (any_active() && c < maxc) begin
      step();
      c++;
    end
    check(name, 32'(c < maxc), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int glog_at(input int k);
    return (glog.size() > k) ? glog[k] : -1;
  endfunction

  initial begin
    int p0, a0, c;
    clear_src();
    bus.pix_x = '0; bus.pix_y = '0; bus.pix_colour = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.gnt, bus.gnt_id, bus.busy, bus.abort, bus.vga_x,
                            bus.vga_y, bus.vga_colour, bus.vga_plot}, 32'd0);
    rst = 1'b0;

    // Single 25-pixel burst from source 0, then show rr_ptr moved to 1.
    p0 = n_plots;
    start_burst(0, 25, -1);
    wait_idle(100, "t1_done");
    check("t1_plots", 32'(n_plots - p0), 32'd25);
    glog.delete(); gaplog.delete(); log_en = 1'b1;
    start_burst(0, 1, -1); start_burst(1, 1, -1);
    wait_idle(50, "t1b_done");
    check("t1_rr_first", 32'(glog_at(0)), 32'd1);
    check("t1_rr_second", 32'(glog_at(1)), 32'd0);

    // All three request together; source 0 re-requests after its burst.
    do_reset();
    glog.delete(); gaplog.delete();
    start_burst(0, 2, -1); start_burst(1, 2, -1); start_burst(2, 2, -1);
    c = 0;
    while (s_phase[0] != 0 && c < 50) begin step(); c++; end
    check("t2_src0_done", 32'(c < 50), 32'd1);
    start_burst(0, 2, -1);
    wait_idle(100, "t2_done");
    check("t2_ngrants", 32'(glog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_order%0d", k), 32'(glog_at(k)), 32'((k == 3) ? 0 : k));
      if (k > 0) check($sformatf("t2_gap%0d", k), 32'((gaplog.size() > k) ? gaplog[k] : -1), 32'd1);
    end
    log_en = 1'b0;

    // Non-granted source floods x=50; it must never reach the VGA port.
    g50 = 1'b1; seen50 = 0; p0 = n_plots;
    start_burst(1, 6, -1);
    wait_idle(60, "t3_done");
    g50 = 1'b0;
    check("t3_plots", 32'(n_plots - p0), 32'd6);
    check("t3_no_x50", 32'(seen50), 32'd0);

    // Source 0 aborts after 3 pixels; source 1 follows.
    do_reset();
    glog.delete(); gaplog.delete(); log_en = 1'b1;
    a0 = n_aborts; p0 = n_plots;
    start_burst(0, 10, 3); start_burst(1, 2, -1);
    wait_idle(80, "t4_done");
    check("t4_aborts", 32'(n_aborts - a0), 32'd1);
    check("t4_plots", 32'(n_plots - p0), 32'd5);
    check("t4_first", 32'(glog_at(0)), 32'd0);
    check("t4_next", 32'(glog_at(1)), 32'd1);

    // Asynchronous reset mid-burst.
    start_burst(2, 20, -1);
    repeat (6) step();
    check("t5_granted", 32'(bus.gnt), 32'b100);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_gnt", 32'(bus.gnt), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_plot", 32'(bus.vga_plot), 32'd0);
    clear_src();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    glog.delete(); gaplog.delete();
    start_burst(1, 1, -1); start_burst(2, 1, -1);
    wait_idle(50, "t5_done");
    check("t5_after_rst", 32'(glog_at(0)), 32'd1);
    log_en = 1'b0;

    // Screen-edge pixels.
    fx = '{159, 160, 5}; fy = '{119, 10, 120};
    p0 = n_plots;
    start_burst(0, 3, -1);
    wait_idle(50, "t6_done");
`ifdef PLOT_CLIP_EN
    check("t6_plots", 32'(n_plots - p0), 32'd1);
`else
    check("t6_plots", 32'(n_plots - p0), 32'd3);
`endif

    // Randomized traffic with gaps, aborts and background noise.
    auto_en = 1'b1; valid_pct = 75;
    repeat (3000) step();
    auto_en = 1'b0;
    wait_idle(400, "rand_drain");
    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("never_x50", 32'(seen50), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
